// File: rtl/mesh_eject_rx.sv
// mesh_eject_rx: receive stage behind the mesh router's eject port.
// Filters flits by destination node ID and buffers the accepted payloads in a
// FIFO. A Wishbone slave in region 0x9xxxxxxx exposes RX_DATA, STATUS and
// CTRL, and rx_irq stays high while data is pending.
module mesh_eject_rx #(
    parameter logic [3:0]  MY_ID      = 4'b0000,
    parameter int unsigned DEPTH      = 8,
    parameter int unsigned DEPTH_LOG2 = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [33:0] eject_flit,
    input  logic [31:0] wb_adr,
    input  logic [31:0] wb_dat_o,
    output logic [31:0] wb_dat_i,
    input  logic        wb_we,
    input  logic        wb_stb,
    output logic        wb_ack,
    output logic        rx_irq
);

    localparam int unsigned PW = DEPTH_LOG2 + 1;
    typedef logic [PW-1:0] ptr_t;

    // Payload storage; needs no reset because occupancy is tracked by pointers.
    logic [28:0] mem_q [DEPTH];

    ptr_t        wr_ptr_q, wr_ptr_d;
    ptr_t        rd_ptr_q, rd_ptr_d;
    logic        overflow_q, overflow_d;
    logic        misroute_q, misroute_d;
    logic [7:0]  drop_cnt_q, drop_cnt_d;
    logic        ack_q, ack_d;
    logic [31:0] dat_q, dat_d;
    logic        irq_q, irq_d;

    ptr_t        count;
    logic        empty;
    logic        full;
    logic [28:0] head;

    logic        wb_accept;
    logic [1:0]  reg_sel;
    logic        pop;
    logic        ctrl_wr;
    logic        flush;
    logic        clr_sticky;
    logic        flit_valid;
    logic        flit_match;
    logic        push;
    logic        ovf_evt;
    logic        mis_evt;
    logic [31:0] status;
    logic [31:0] rd_data;
    logic [7:0]  drop_base;

    // Address and write-data bits that carry no meaning for this block.
    logic unused_bits;
    assign unused_bits = ^{wb_adr[27:4], wb_adr[1:0], wb_dat_o[31:2]};

    assign count = wr_ptr_q - rd_ptr_q;
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[PW-1] != rd_ptr_q[PW-1]) &&
                   (wr_ptr_q[PW-2:0] == rd_ptr_q[PW-2:0]);
    assign head  = mem_q[rd_ptr_q[PW-2:0]];

    assign wb_accept  = wb_stb && !ack_q && (wb_adr[31:28] == 4'h9);
    assign reg_sel    = wb_adr[3:2];
    assign pop        = wb_accept && !wb_we && (reg_sel == 2'd0) && !empty;
    assign ctrl_wr    = wb_accept && wb_we && (reg_sel == 2'd2);
    assign flush      = ctrl_wr && wb_dat_o[0];
    assign clr_sticky = ctrl_wr && wb_dat_o[1];

    assign flit_valid = eject_flit[33];
    assign flit_match = (eject_flit[32:29] == MY_ID);
    // A pop in the same cycle frees a slot, so a full FIFO can still accept.
    assign push       = flit_valid && flit_match && !flush && (!full || pop);
    assign ovf_evt    = flit_valid && flit_match && !flush && full && !pop;
    assign mis_evt    = flit_valid && !flit_match;

    // STATUS layout: count moves up to [15:8] when it no longer fits in 4 bits.
    always_comb begin
        status = '0;
        if (DEPTH <= 8) begin
            status = {16'h0, drop_cnt_q, misroute_q, overflow_q, full, empty, 4'(count)};
        end else begin
            status = {8'h0, drop_cnt_q, 8'(count), misroute_q, overflow_q, full, empty, 4'h0};
        end
    end

    // Read data mux; RX_DATA reflects the pre-push state of this cycle.
    always_comb begin
        rd_data = '0;
        if (!wb_we) begin
            case (reg_sel)
                2'd0: if (!empty) rd_data = {1'b1, 2'b00, head};
                2'd1: rd_data = status;
                default: rd_data = '0;
            endcase
        end
    end

    // Next-state for pointers, sticky flags, drop counter and bus outputs.
    always_comb begin
        wr_ptr_d   = flush ? '0 : wr_ptr_q + ptr_t'(push);
        rd_ptr_d   = flush ? '0 : rd_ptr_q + ptr_t'(pop);
        irq_d      = (wr_ptr_d != rd_ptr_d);
        // Clearing happens first so that a same-cycle event still sets.
        overflow_d = ovf_evt || (overflow_q && !clr_sticky);
        misroute_d = mis_evt || (misroute_q && !clr_sticky);
        drop_base  = clr_sticky ? 8'h00 : drop_cnt_q;
        drop_cnt_d = drop_base;
        if (ovf_evt && (drop_base != 8'hFF)) begin
            drop_cnt_d = drop_base + 8'h01;
        end
        ack_d = wb_accept;
        dat_d = wb_accept ? rd_data : '0;
    end

    // FIFO payload write.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q[PW-2:0]] <= eject_flit[28:0];
        end
    end

    // Control and status state with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            overflow_q <= 1'b0;
            misroute_q <= 1'b0;
            drop_cnt_q <= '0;
            ack_q      <= 1'b0;
            dat_q      <= '0;
            irq_q      <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            overflow_q <= overflow_d;
            misroute_q <= misroute_d;
            drop_cnt_q <= drop_cnt_d;
            ack_q      <= ack_d;
            dat_q      <= dat_d;
            irq_q      <= irq_d;
        end
    end

    assign wb_ack   = ack_q;
    assign wb_dat_i = dat_q;
    assign rx_irq   = irq_q;

endmodule

// File: tb/tb_mesh_eject_rx.sv
// Bench for mesh_eject_rx at node 4'b0101 with an 8-entry FIFO.
// Expected RX_DATA words go into a queue as flits are injected and come out
// as the CPU reads them back.
module tb_mesh_eject_rx;

    localparam logic [3:0] NODE = 4'b0101;
    localparam logic [31:0] A_DATA = 32'h9000_0000;
    localparam logic [31:0] A_STAT = 32'h9000_0004;
    localparam logic [31:0] A_CTRL = 32'h9000_0008;

    logic        clk;
    logic        rst_n;
    logic [33:0] eject_flit;
    logic [31:0] wb_adr;
    logic [31:0] wb_dat_o;
    logic [31:0] wb_dat_i;
    logic        wb_we;
    logic        wb_stb;
    logic        wb_ack;
    logic        rx_irq;

    int checks;
    int errors;
    logic [31:0] exp_q [$];

    mesh_eject_rx #(
        .MY_ID      (NODE),
        .DEPTH      (8),
        .DEPTH_LOG2 (3)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .eject_flit (eject_flit),
        .wb_adr     (wb_adr),
        .wb_dat_o   (wb_dat_o),
        .wb_dat_i   (wb_dat_i),
        .wb_we      (wb_we),
        .wb_stb     (wb_stb),
        .wb_ack     (wb_ack),
        .rx_irq     (rx_irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_flit(input logic [3:0] dest, input logic [28:0] pl);
        eject_flit = {1'b1, dest, pl};
        tick();
        eject_flit = '0;
    endtask

    // Bus cycle with a bounded wait for the acknowledge.
    task automatic wb_xfer(input logic [31:0] adr, input logic we, input logic [31:0] wdat,
                           output logic [31:0] rdat, output logic acked);
        wb_adr   = adr;
        wb_we    = we;
        wb_dat_o = wdat;
        wb_stb   = 1'b1;
        acked    = 1'b0;
        rdat     = '0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (wb_ack) begin
                acked = 1'b1;
                rdat  = wb_dat_i;
                break;
            end
        end
        wb_stb = 1'b0;
        wb_we  = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] rd;
        logic ak;
        rst_n = 1'b0;
        #3;
        checks++;
        if ({wb_ack, wb_dat_i, rx_irq} !== 34'h0) begin
            errors++;
            $display("FAIL reset_outputs: ack=%b dat=%h irq=%b, required all 0", wb_ack, wb_dat_i, rx_irq);
        end
        tick();
        rst_n = 1'b1;
        tick();
        wb_xfer(A_STAT, 1'b0, '0, rd, ak);
        checks++;
        if (!ak || rd !== 32'h0000_0010) begin
            errors++;
            $display("FAIL reset_status: ack=%b got %h, required %h", ak, rd, 32'h0000_0010);
        end
    endtask

    task automatic test_single();
        logic [31:0] rd;
        logic [31:0] ex;
        logic ak;
        send_flit(NODE, 29'h1);
        exp_q.push_back(32'h8000_0001);
        checks++;
        if (rx_irq !== 1'b1) begin
            errors++;
            $display("FAIL single_irq_rise: got %b, required 1", rx_irq);
        end
        wb_xfer(A_STAT, 1'b0, '0, rd, ak);
        checks++;
        if (!ak || rd !== 32'h0000_0001) begin
            errors++;
            $display("FAIL single_status: ack=%b got %h, required %h", ak, rd, 32'h0000_0001);
        end
        wb_xfer(A_DATA, 1'b0, '0, rd, ak);
        ex = exp_q.pop_front();
        checks++;
        if (!ak || rd !== ex) begin
            errors++;
            $display("FAIL single_rx_data: ack=%b got %h, required %h", ak, rd, ex);
        end
        checks++;
        if (rx_irq !== 1'b0) begin
            errors++;
            $display("FAIL single_irq_fall: got %b, required 0", rx_irq);
        end
        wb_xfer(A_STAT, 1'b0, '0, rd, ak);
        checks++;
        if (!ak || rd !== 32'h0000_0010) begin
            errors++;
            $display("FAIL single_status_after: ack=%b got %h, required %h", ak, rd, 32'h0000_0010);
        end
    endtask

    task automatic test_overflow();
        logic [31:0] rd;
        logic [31:0] ex;
        logic ak;
        for (int i = 1; i <= 9; i++) begin
            send_flit(NODE, 29'(i));
            if (i <= 8) exp_q.push_back({3'b100, 29'(i)});
        end
        wb_xfer(A_STAT, 1'b0, '0, rd, ak);
        checks++;
        if (!ak || rd !== 32'h0000_0168) begin
            errors++;
            $display("FAIL overflow_status: ack=%b got %h, required %h", ak, rd, 32'h0000_0168);
        end
        for (int i = 0; i < 9; i++) begin
            wb_xfer(A_DATA, 1'b0, '0, rd, ak);
            ex = (exp_q.size() > 0) ? exp_q.pop_front() : 32'h0;
            checks++;
            if (!ak || rd !== ex) begin
                errors++;
                $display("FAIL overflow_read%0d: ack=%b got %h, required %h", i, ak, rd, ex);
            end
        end
        wb_xfer(A_CTRL, 1'b1, 32'h2, rd, ak);
        wb_xfer(A_STAT, 1'b0, '0, rd, ak);
        checks++;
        if (!ak || rd !== 32'h0000_0010) begin
            errors++;
            $display("FAIL overflow_clear: ack=%b got %h, required %h", ak, rd, 32'h0000_0010);
        end
    endtask

    task automatic test_misroute();
        logic [31:0] rd;
        logic ak;
        send_flit(4'b0000, 29'h5);
        wb_xfer(A_STAT, 1'b0, '0, rd, ak);
        checks++;
        if (!ak || rd !== 32'h0000_0090) begin
            errors++;
            $display("FAIL misroute_status: ack=%b got %h, required %h", ak, rd, 32'h0000_0090);
        end
        wb_xfer(A_CTRL, 1'b1, 32'h2, rd, ak);
        checks++;
        if (!ak || rd !== 32'h0) begin
            errors++;
            $display("FAIL ctrl_write_ack: ack=%b got %h, required %h", ak, rd, 32'h0);
        end
        wb_xfer(A_STAT, 1'b0, '0, rd, ak);
        checks++;
        if (!ak || rd !== 32'h0000_0010) begin
            errors++;
            $display("FAIL misroute_clear: ack=%b got %h, required %h", ak, rd, 32'h0000_0010);
        end
    endtask

    task automatic test_full_pop_push();
        logic [31:0] rd;
        logic [31:0] ex;
        logic ak;
        for (int i = 0; i < 8; i++) begin
            send_flit(NODE, 29'(32'h100 + i));
            exp_q.push_back({3'b100, 29'(32'h100 + i)});
        end
        tick();
        wb_adr     = A_DATA;
        wb_we      = 1'b0;
        wb_stb     = 1'b1;
        eject_flit = {1'b1, NODE, 29'h1AB};
        tick();
        eject_flit = '0;
        wb_stb     = 1'b0;
        ex = exp_q.pop_front();
        exp_q.push_back({3'b100, 29'h1AB});
        checks++;
        if (wb_ack !== 1'b1 || wb_dat_i !== ex) begin
            errors++;
            $display("FAIL fullpop_read: ack=%b got %h, required %h", wb_ack, wb_dat_i, ex);
        end
        wb_xfer(A_STAT, 1'b0, '0, rd, ak);
        checks++;
        if (!ak || rd !== 32'h0000_0028) begin
            errors++;
            $display("FAIL fullpop_status: ack=%b got %h, required %h", ak, rd, 32'h0000_0028);
        end
        for (int i = 0; i < 8; i++) begin
            wb_xfer(A_DATA, 1'b0, '0, rd, ak);
            ex = (exp_q.size() > 0) ? exp_q.pop_front() : 32'h0;
            checks++;
            if (!ak || rd !== ex) begin
                errors++;
                $display("FAIL fullpop_drain%0d: ack=%b got %h, required %h", i, ak, rd, ex);
            end
        end
    endtask

    task automatic test_flush_wrap();
        logic [31:0] rd;
        logic [31:0] ex;
        logic ak;
        for (int i = 0; i < 3; i++) send_flit(NODE, 29'(32'h300 + i));
        tick();
        wb_adr     = A_CTRL;
        wb_we      = 1'b1;
        wb_dat_o   = 32'h1;
        wb_stb     = 1'b1;
        eject_flit = {1'b1, NODE, 29'h3FF};
        tick();
        eject_flit = '0;
        wb_stb     = 1'b0;
        wb_we      = 1'b0;
        checks++;
        if (wb_ack !== 1'b1) begin
            errors++;
            $display("FAIL flush_ack: got %b, required 1", wb_ack);
        end
        wb_xfer(A_STAT, 1'b0, '0, rd, ak);
        checks++;
        if (!ak || rd !== 32'h0000_0010) begin
            errors++;
            $display("FAIL flush_status: ack=%b got %h, required %h", ak, rd, 32'h0000_0010);
        end
        for (int i = 0; i < 20; i++) begin
            send_flit(NODE, 29'(32'h1000 + i * 7));
            exp_q.push_back({3'b100, 29'(32'h1000 + i * 7)});
            if (i % 3 != 2) begin
                wb_xfer(A_DATA, 1'b0, '0, rd, ak);
                ex = (exp_q.size() > 0) ? exp_q.pop_front() : 32'h0;
                checks++;
                if (!ak || rd !== ex) begin
                    errors++;
                    $display("FAIL wrap_read%0d: ack=%b got %h, required %h", i, ak, rd, ex);
                end
            end
        end
        while (exp_q.size() > 0) begin
            wb_xfer(A_DATA, 1'b0, '0, rd, ak);
            ex = exp_q.pop_front();
            checks++;
            if (!ak || rd !== ex) begin
                errors++;
                $display("FAIL wrap_drain: ack=%b got %h, required %h", ak, rd, ex);
            end
        end
        checks++;
        if (rx_irq !== 1'b0) begin
            errors++;
            $display("FAIL wrap_irq: got %b, required 0", rx_irq);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd;
        logic ak;
        send_flit(NODE, 29'h55);
        send_flit(NODE, 29'h66);
        tick();
        wb_adr = A_STAT;
        wb_we  = 1'b0;
        wb_stb = 1'b1;
        tick();
        rst_n = 1'b0;
        #1;
        checks++;
        if (wb_ack !== 1'b0 || rx_irq !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid: ack=%b irq=%b, required 0 0", wb_ack, rx_irq);
        end
        wb_stb = 1'b0;
        exp_q.delete();
        tick();
        rst_n = 1'b1;
        tick();
        wb_xfer(32'h8000_0000, 1'b0, '0, rd, ak);
        checks++;
        if (ak !== 1'b0) begin
            errors++;
            $display("FAIL region8_ack: got %b, required 0", ak);
        end
        wb_xfer(A_STAT, 1'b0, '0, rd, ak);
        checks++;
        if (!ak || rd !== 32'h0000_0010) begin
            errors++;
            $display("FAIL reset_mid_status: ack=%b got %h, required %h", ak, rd, 32'h0000_0010);
        end
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        rst_n      = 1'b0;
        eject_flit = '0;
        wb_adr     = '0;
        wb_dat_o   = '0;
        wb_we      = 1'b0;
        wb_stb     = 1'b0;
        test_reset();
        test_single();
        test_overflow();
        test_misroute();
        test_full_pop_push();
        test_flush_wrap();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
